// File: rtl/l1c_victim_buffer_pkg.sv
// l1c_victim_buffer_pkg: shared L1C config, victim buffer entry type and drain FSM states
package l1c_victim_buffer_pkg;
  localparam int L1C_DATA_WIDTH = 512;
  localparam int L1C_ADDR_WIDTH = 48;
  localparam int L1C_OFFSET = 6;
  localparam int L1C_LA_W = L1C_ADDR_WIDTH - L1C_OFFSET;
  localparam int L1C_VB_DEPTH = 16;
  localparam int L1C_VB_DRAIN_THRESH = 12;
  localparam int L1C_VB_IDLE_LIMIT = 16;
  typedef struct packed {
    logic [L1C_LA_W-1:0] addr;
    logic [L1C_DATA_WIDTH-1:0] data;
  } vb_entry_t;
  typedef enum logic {VB_IDLE, VB_DRAIN} vb_state_e;
endpackage

// File: rtl/l1c_vb_cam.sv
// l1c_vb_cam: youngest-match address search over occupied victim buffer entries
module l1c_vb_cam #(
  parameter int LA_W = 42,
  parameter int DEPTH = 16
) (
  input  logic [DEPTH-1:0]         occ,
  input  logic [LA_W-1:0]          addrs [DEPTH],
  input  logic [LA_W-1:0]          key,
  input  logic [$clog2(DEPTH)-1:0] head,
  output logic [DEPTH-1:0]         match_oh,
  output logic                     hit
);
  localparam int PW = $clog2(DEPTH);
  logic [DEPTH-1:0] match;
  for (genvar i = 0; i < DEPTH; i++) begin : g_cmp
    assign match[i] = occ[i] && addrs[i] == key;
  end
  assign hit = |match;
  always_comb begin
    match_oh = '0;
    for (int k = 0; k < DEPTH; k++)
      if (match[head + PW'(k)]) begin
        match_oh = '0;
        match_oh[head + PW'(k)] = 1'b1;
      end
  end
endmodule

// File: rtl/l1c_victim_buffer.sv
// l1c_victim_buffer: dirty-line victim FIFO with threshold/idle/flush drain FSM; forwarding built under L1C_VB_FORWARD_EN
module l1c_victim_buffer
  import l1c_victim_buffer_pkg::*;
#(
  parameter int DATA_WIDTH = L1C_DATA_WIDTH,
  parameter int ADDR_WIDTH = L1C_ADDR_WIDTH,
  parameter int OFFSET = L1C_OFFSET,
  parameter int DEPTH = L1C_VB_DEPTH,
  parameter int DRAIN_THRESH = L1C_VB_DRAIN_THRESH,
  parameter int IDLE_LIMIT = L1C_VB_IDLE_LIMIT
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         evict_valid_i,
  output logic                         evict_ready_o,
  input  logic                         evict_dirty_i,
  input  logic [ADDR_WIDTH-OFFSET-1:0] evict_addr_i,
  input  logic [DATA_WIDTH-1:0]        evict_data_i,
  output logic                         wb_valid_o,
  input  logic                         wb_ready_i,
  output logic [ADDR_WIDTH-OFFSET-1:0] wb_addr_o,
  output logic [DATA_WIDTH-1:0]        wb_data_o,
  input  logic                         lookup_valid_i,
  input  logic [ADDR_WIDTH-OFFSET-1:0] lookup_addr_i,
  output logic                         lookup_hit_o,
  output logic [DATA_WIDTH-1:0]        lookup_data_o,
  input  logic                         flush_i,
  output logic [$clog2(DEPTH+1)-1:0]   count_o,
  output logic                         empty_o
);
  localparam int LA_W = ADDR_WIDTH - OFFSET;
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int IW = $clog2(IDLE_LIMIT + 1);
  vb_state_e state_q;
  logic [PW-1:0] head_q, tail_q;
  logic [CW-1:0] count_q;
  logic [IW-1:0] idle_q;
  logic [LA_W-1:0] addr_q [DEPTH];
  logic [DATA_WIDTH-1:0] data_q [DEPTH];
  logic empty, push, pop;
  assign empty = count_q == '0;
  assign evict_ready_o = count_q != CW'(DEPTH);
  assign push = evict_valid_i && evict_ready_o && evict_dirty_i;
  assign wb_valid_o = state_q == VB_DRAIN && !empty;
  assign pop = wb_valid_o && wb_ready_i;
  assign count_o = count_q;
  assign empty_o = empty;
  assign wb_addr_o = empty ? '0 : addr_q[head_q];
  assign wb_data_o = empty ? '0 : data_q[head_q];
  always_ff @(posedge clk_i)
    if (push) begin
      addr_q[tail_q] <= evict_addr_i;
      data_q[tail_q] <= evict_data_i;
    end
  always_ff @(posedge clk_i)
    if (rst_i) begin
      state_q <= VB_IDLE;
      head_q <= '0;
      tail_q <= '0;
      count_q <= '0;
      idle_q <= '0;
    end else begin
      head_q <= head_q + PW'(pop);
      tail_q <= tail_q + PW'(push);
      count_q <= count_q + CW'(push) - CW'(pop);
      if (state_q == VB_IDLE) begin
        idle_q <= (push || empty) ? '0 : idle_q + IW'(1);
        if (count_q >= CW'(DRAIN_THRESH) || flush_i || idle_q == IW'(IDLE_LIMIT - 1))
          state_q <= VB_DRAIN;
      end else begin
        idle_q <= '0;
        if (empty || (count_q == CW'(1) && pop && !push))
          state_q <= VB_IDLE;
      end
    end
`ifdef L1C_VB_FORWARD_EN
  logic [DEPTH-1:0] occ, match_oh;
  logic cam_hit;
  for (genvar i = 0; i < DEPTH; i++) begin : g_occ
    logic [PW-1:0] off;
    assign off = PW'(i) - head_q;
    assign occ[i] = CW'(off) < count_q;
  end
  l1c_vb_cam #(.LA_W(LA_W), .DEPTH(DEPTH)) u_cam (
    .occ(occ),
    .addrs(addr_q),
    .key(lookup_addr_i),
    .head(head_q),
    .match_oh(match_oh),
    .hit(cam_hit)
  );
  assign lookup_hit_o = lookup_valid_i && cam_hit;
  always_comb begin
    lookup_data_o = '0;
    for (int i = 0; i < DEPTH; i++)
      lookup_data_o = lookup_data_o | ((lookup_valid_i && match_oh[i]) ? data_q[i] : '0);
  end
`else
  logic unused_lookup;
  assign unused_lookup = ^{lookup_valid_i, lookup_addr_i};
  assign lookup_hit_o = 1'b0;
  assign lookup_data_o = '0;
`endif
endmodule

// File: tb/tb_l1c_victim_buffer.sv
// tb_l1c_victim_buffer: scoreboard bench for l1c_victim_buffer drain order, timing, stall hold, lookup and reset
module tb_l1c_victim_buffer;
  localparam int DEPTH = 16;
  localparam int DW = 512;
  localparam int LA_W = 42;
`ifdef L1C_VB_FORWARD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif
  typedef struct {
    logic [LA_W-1:0] a;
    logic [DW-1:0] d;
  } ent_t;
  logic clk_i = 1'b0;
  logic rst_i;
  logic evict_valid_i, evict_ready_o, evict_dirty_i;
  logic [LA_W-1:0] evict_addr_i, wb_addr_o, lookup_addr_i;
  logic [DW-1:0] evict_data_i, wb_data_o, lookup_data_o;
  logic wb_valid_o, wb_ready_i, lookup_valid_i, lookup_hit_o, flush_i, empty_o;
  logic [4:0] count_o;
  ent_t sb[$];
  int model_cnt = 0;
  int compared = 0;
  int mismatched = 0;
  logic prev_stall = 1'b0;
  logic [LA_W-1:0] prev_addr;
  logic [DW-1:0] prev_data;
  logic [DW-1:0] data_a, data_b;
  always #5 clk_i = ~clk_i;
  l1c_victim_buffer dut (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .evict_valid_i(evict_valid_i),
    .evict_ready_o(evict_ready_o),
    .evict_dirty_i(evict_dirty_i),
    .evict_addr_i(evict_addr_i),
    .evict_data_i(evict_data_i),
    .wb_valid_o(wb_valid_o),
    .wb_ready_i(wb_ready_i),
    .wb_addr_o(wb_addr_o),
    .wb_data_o(wb_data_o),
    .lookup_valid_i(lookup_valid_i),
    .lookup_addr_i(lookup_addr_i),
    .lookup_hit_o(lookup_hit_o),
    .lookup_data_o(lookup_data_o),
    .flush_i(flush_i),
    .count_o(count_o),
    .empty_o(empty_o)
  );
  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic logic [DW-1:0] rnd_line();
    logic [DW-1:0] d;
    for (int i = 0; i < DW / 32; i++) d[i*32 +: 32] = $urandom();
    return d;
  endfunction
  task automatic tick();
    ent_t e;
    int pre;
    pre = model_cnt;
    if (!rst_i) begin
      check("count", count_o, model_cnt);
      check("empty", empty_o, model_cnt == 0);
      check("ready", evict_ready_o, model_cnt != DEPTH);
      if (prev_stall) begin
        check("hold_v", wb_valid_o, 1);
        check("hold_a", wb_addr_o, prev_addr);
        check("hold_d", wb_data_o, prev_data);
      end
      prev_stall = wb_valid_o && !wb_ready_i;
      prev_addr = wb_addr_o;
      prev_data = wb_data_o;
      if (wb_valid_o && wb_ready_i) begin
        if (sb.size() == 0) check("wb_spur", wb_valid_o, 0);
        else begin
          e = sb.pop_front();
          check("wb_addr", wb_addr_o, e.a);
          check("wb_data", wb_data_o, e.d);
          model_cnt--;
        end
      end
      if (evict_valid_i && evict_dirty_i && pre != DEPTH) begin
        e.a = evict_addr_i;
        e.d = evict_data_i;
        sb.push_back(e);
        model_cnt++;
      end
    end
    @(posedge clk_i);
    @(negedge clk_i);
    if (rst_i) begin
      sb.delete();
      model_cnt = 0;
      prev_stall = 1'b0;
    end
  endtask
  task automatic push_line(input logic [LA_W-1:0] a, input logic [DW-1:0] d, input logic dirty);
    evict_valid_i = 1'b1;
    evict_dirty_i = dirty;
    evict_addr_i = a;
    evict_data_i = d;
    tick();
    evict_valid_i = 1'b0;
  endtask
  task automatic drain(input string tag);
    int n = 0;
    while (sb.size() != 0 && n < 60) begin
      tick();
      n++;
    end
    check(tag, sb.size(), 0);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    int n;
    rst_i = 1'b1;
    evict_valid_i = 1'b0;
    evict_dirty_i = 1'b0;
    evict_addr_i = '0;
    evict_data_i = '0;
    wb_ready_i = 1'b0;
    lookup_valid_i = 1'b0;
    lookup_addr_i = '0;
    flush_i = 1'b0;
    @(negedge clk_i);
    tick();
    tick();
    rst_i = 1'b0;
    check("rst_ready", evict_ready_o, 1);
    check("rst_wbv", wb_valid_o, 0);
    check("rst_empty", empty_o, 1);
    check("rst_count", count_o, 0);
    check("rst_hit", lookup_hit_o, 0);
    check("rst_wba", wb_addr_o, 0);
    check("rst_wbd", wb_data_o, 0);
    check("rst_lkd", lookup_data_o, 0);
    wb_ready_i = 1'b1;
    for (int i = 0; i < 12; i++) push_line(LA_W'('h100 + i), rnd_line(), 1'b1);
    check("thr_wbv0", wb_valid_o, 0);
    tick();
    check("thr_wbv1", wb_valid_o, 1);
    drain("thr_drain");
    check("thr_empty", empty_o, 1);
    tick();
    check("thr_idle", wb_valid_o, 0);
    push_line(LA_W'('h200), rnd_line(), 1'b1);
    n = 0;
    while (!wb_valid_o && n < 40) begin
      tick();
      n++;
    end
    check("idle_lat", n, 16);
    drain("idle_drain");
    push_line(LA_W'('h999), rnd_line(), 1'b0);
    check("clean_cnt", count_o, 0);
    check("clean_rdy", evict_ready_o, 1);
    wb_ready_i = 1'b0;
    for (int i = 0; i < 16; i++) push_line(LA_W'('h300 + i), rnd_line(), 1'b1);
    check("full_rdy", evict_ready_o, 0);
    push_line(LA_W'('h3FF), rnd_line(), 1'b1);
    for (int i = 0; i < 5; i++) begin
      check("stall_a", wb_addr_o, LA_W'('h300));
      tick();
    end
    wb_ready_i = 1'b1;
    for (int k = 0; k < 16; k++) begin
      check("dec_cnt", count_o, 16 - k);
      tick();
    end
    check("dec_empty", empty_o, 1);
    wb_ready_i = 1'b0;
    data_a = rnd_line();
    data_b = ~data_a;
    push_line(LA_W'('h2A), data_a, 1'b1);
    push_line(LA_W'('h2A), data_b, 1'b1);
    lookup_valid_i = 1'b1;
    lookup_addr_i = LA_W'('h2A);
    #1;
    check("lk_hit", lookup_hit_o, FWD);
    check("lk_data", lookup_data_o, FWD ? data_b : '0);
    lookup_addr_i = LA_W'('h2B);
    #1;
    check("lk_miss", lookup_hit_o, 0);
    check("lk_mdata", lookup_data_o, 0);
    lookup_valid_i = 1'b0;
    lookup_addr_i = LA_W'('h2A);
    #1;
    check("lk_inval", lookup_hit_o, 0);
    flush_i = 1'b1;
    wb_ready_i = 1'b1;
    drain("lk_drain");
    flush_i = 1'b0;
    wb_ready_i = 1'b0;
    tick();
    for (int i = 0; i < 8; i++) push_line(LA_W'('h500 + i), rnd_line(), 1'b1);
    flush_i = 1'b1;
    tick();
    check("ff_wbv", wb_valid_o, 1);
    wb_ready_i = 1'b1;
    for (int i = 0; i < 20; i++) begin
      check("ff_cnt", count_o, 8);
      push_line(LA_W'('h600 + i), rnd_line(), 1'b1);
    end
    drain("ff_drain");
    wb_ready_i = 1'b0;
    for (int i = 0; i < 5; i++) push_line(LA_W'('h700 + i), rnd_line(), 1'b1);
    check("mid_wbv", wb_valid_o, 1);
    check("mid_cnt", count_o, 5);
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    flush_i = 1'b0;
    check("rr_cnt", count_o, 0);
    check("rr_wbv", wb_valid_o, 0);
    check("rr_rdy", evict_ready_o, 1);
    check("rr_empty", empty_o, 1);
    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/l1c_victim_buffer.md
# l1c_victim_buffer

Buffers dirty lines evicted from the direct-mapped L1 data cache and drains them to the home node over a valid/ready write-back channel. Sits directly downstream of the L1C tag/data arrays on the eviction path. Decouples refill from write-back and lets the cache forward data from lines still in flight. Drain is driven by a small FSM using occupancy threshold, idle timeout and explicit flush.

## Interface
Parameters:
- DATA_WIDTH, 512, cache line width in bits
- ADDR_WIDTH, 48, physical address width
- OFFSET, 6, line-offset bits; line address width LA_W = ADDR_WIDTH-OFFSET = 42
- DEPTH, 16, entry count (power of two)
- DRAIN_THRESH, 12, occupancy that forces drain
- IDLE_LIMIT, 16, idle cycles with non-empty buffer before drain

Ports (one clock; reset is synchronous and active-high):
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- evict_valid_i  in  1  eviction offered
- evict_ready_o  out  1  eviction accepted when high with valid
- evict_dirty_i  in  1  line dirty; clean lines accepted and discarded
- evict_addr_i  in  LA_W  evicted line address
- evict_data_i  in  DATA_WIDTH  evicted line data
- wb_valid_o  out  1  write-back request valid
- wb_ready_i  in  1  home node accepts
- wb_addr_o  out  LA_W  head line address
- wb_data_o  out  DATA_WIDTH  head line data
- lookup_valid_i  in  1  cache miss probing buffer
- lookup_addr_i  in  LA_W  probed line address
- lookup_hit_o  out  1  probed line present (combinational)
- lookup_data_o  out  DATA_WIDTH  data of matching entry
- flush_i  in  1  level: drain until empty
- count_o  out  $clog2(DEPTH+1)  occupancy
- empty_o  out  1  count_o == 0

## Operation
- Circular FIFO: head/tail pointers log2(DEPTH) bits, wrap DEPTH-1 -> 0; separate count register.
- Push: evict_valid_i && evict_ready_o && evict_dirty_i writes {addr,data} at tail, tail++. Clean handshake consumes nothing.
- evict_ready_o = (count_o != DEPTH); no push-through-pop when full, even if pop occurs same cycle.
- Pop: wb_valid_o && wb_ready_i, head++.
- Simultaneous push and pop: count unchanged, both pointers advance.
- FSM IDLE/DRAIN. IDLE: wb_valid_o=0; idle counter increments each cycle when non-empty and no push, clears on push or empty. IDLE->DRAIN when count_o >= DRAIN_THRESH, flush_i, or idle counter == IDLE_LIMIT-1.
- DRAIN: wb_valid_o = !empty_o; DRAIN->IDLE only when empty (including when last entry pops this cycle, next state IDLE). wb_valid_o never drops before handshake; wb_addr_o/wb_data_o stable while valid && !ready.
- Lookup: compare lookup_addr_i with all occupied entries; multiple matches -> youngest (nearest tail) wins. Entry popping this cycle still hits. lookup_hit_o=0 when lookup_valid_i=0; lookup_data_o = 0 on miss.
- Duplicate addresses allowed; drain order strictly FIFO.

## Timing
- Reset: head=tail=count=0, FSM IDLE, idle counter 0; evict_ready_o=1, wb_valid_o=0, empty_o=1, count_o=0, lookup_hit_o=0, wb_addr_o/wb_data_o/lookup_data_o=0 (data array not reset; outputs masked when empty).
- Push visible to count_o and lookup next cycle; earliest wb_valid_o one cycle after push that reaches DRAIN_THRESH.
- Lookup: zero-cycle combinational against registered state.
- Reset mid-drain discards all entries; wb_valid_o low in the cycle after rst_i.

## Configuration
- L1C_VB_FORWARD_EN defined: lookup compare logic present as above.
- Undefined: ports retained, lookup_hit_o and lookup_data_o tied 0, no comparators built.

## Structure
- Shared L1C config package holds DATA_WIDTH, line-address width, DEPTH (victim buffer limit) and idle limit, plus new typedef vb_entry_t {addr, data} and enum vb_state_e {VB_IDLE, VB_DRAIN}.
- Sub-module l1c_vb_cam: occupancy mask + addresses in, youngest-match one-hot and hit out; instantiated only under L1C_VB_FORWARD_EN.

## Test plan
- Push 12 dirty lines (addr 0x100..0x10B), wb_ready_i=1 -> DRAIN entered next cycle, 12 write-backs in order 0x100..0x10B, then IDLE, empty_o=1.
- Push 1 dirty line, no further activity -> wb_valid_o rises exactly 16 cycles later; clean eviction -> evict_ready_o=1, count_o stays 0.
- Fill 16 with flush_i=0, wb_ready_i=0 -> evict_ready_o=0; hold wb_ready_i=0 5 cycles -> wb_addr_o/data stable; release -> count_o decrements each cycle.
- Push 0x2A data A then 0x2A data B, lookup 0x2A -> hit, lookup_data_o=B; lookup 0x2B -> miss, data 0.
- Count 8, flush_i=1, push+pop every cycle -> count_o holds 8, pointers wrap past 15 with correct data.
- Assert rst_i mid-drain with count 5 -> next cycle count_o=0, wb_valid_o=0, evict_ready_o=1.
